// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - I2C bus condition decoder: START/rSTART/STOP, bit sampling, bus free, SCL-low timeout
module i2c_bus_monitor #(
  parameter int BUS_FREE_CYCLES = 64,
  parameter int SCL_LOW_TIMEOUT = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_scl_rise,
  output logic       o_scl_fall,
  output logic       o_start,
  output logic       o_rstart,
  output logic       o_stop,
  output logic       o_bit_valid,
  output logic       o_bit,
  output logic [3:0] o_bit_idx,
  output logic       o_busy,
  output logic       o_bus_free,
  output logic       o_tbuf_viol,
  output logic       o_scl_timeout
);

  localparam int FW = $clog2(BUS_FREE_CYCLES + 1);
  localparam int LW = $clog2(SCL_LOW_TIMEOUT + 1);

  typedef enum logic [1:0] {S_FREE_WAIT, S_IDLE, S_BUSY} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_scl_q;
  logic            r_sda_q;
  logic [FW-1:0]   r_free_cnt;
  logic [LW-1:0]   r_low_cnt;
  logic            r_bit_seen;

  logic w_start, w_stop, w_rise, w_fall, w_busy, w_timeout, w_free_done;

  // SCL must be stable high across the SDA change; a simultaneous SCL change is only an edge
  assign w_start     = r_scl_q & i_scl & r_sda_q & ~i_sda;
  assign w_stop      = r_scl_q & i_scl & ~r_sda_q & i_sda;
  assign w_rise      = ~r_scl_q & i_scl;
  assign w_fall      = r_scl_q & ~i_scl;
  assign w_busy      = (r_state == S_BUSY);
  assign w_timeout   = w_busy & ~i_scl & (r_low_cnt >= LW'(SCL_LOW_TIMEOUT - 1));
  assign w_free_done = i_scl & i_sda & (r_free_cnt == FW'(BUS_FREE_CYCLES - 1));

  assign o_busy     = (r_state == S_BUSY);
  assign o_bus_free = (r_state == S_IDLE);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FREE_WAIT: begin
        if (w_start)          w_next_state = S_BUSY;
        else if (w_free_done) w_next_state = S_IDLE;
      end
      S_IDLE: begin
        if (w_start) w_next_state = S_BUSY;
      end
      S_BUSY: begin
        if (w_stop || w_timeout) w_next_state = S_FREE_WAIT;
      end
      default: w_next_state = S_FREE_WAIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FREE_WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_q       <= 1'b1;
      r_sda_q       <= 1'b1;
      r_free_cnt    <= '0;
      r_low_cnt     <= '0;
      r_bit_seen    <= 1'b0;
      o_scl_rise    <= 1'b0;
      o_scl_fall    <= 1'b0;
      o_start       <= 1'b0;
      o_rstart      <= 1'b0;
      o_stop        <= 1'b0;
      o_tbuf_viol   <= 1'b0;
      o_bit_valid   <= 1'b0;
      o_bit         <= 1'b0;
      o_bit_idx     <= 4'd0;
      o_scl_timeout <= 1'b0;
    end else begin
      r_scl_q     <= i_scl;
      r_sda_q     <= i_sda;
      o_scl_rise  <= w_rise;
      o_scl_fall  <= w_fall;
      o_start     <= w_start & ~w_busy;
      o_rstart    <= w_start & w_busy;
      o_stop      <= w_stop & w_busy;
      o_tbuf_viol <= w_start & (r_state == S_FREE_WAIT);
      o_bit_valid <= w_busy & w_rise;

      if (r_state == S_FREE_WAIT && i_scl && i_sda) r_free_cnt <= r_free_cnt + 1'b1;
      else                                          r_free_cnt <= '0;

      if (w_busy && !i_scl) begin
        if (r_low_cnt != LW'(SCL_LOW_TIMEOUT)) r_low_cnt <= r_low_cnt + 1'b1;
      end else begin
        r_low_cnt <= '0;
      end

      if (w_timeout)  o_scl_timeout <= 1'b1;
      else if (i_scl) o_scl_timeout <= 1'b0;

      if (w_busy && w_rise) begin
        o_bit      <= i_sda;
        r_bit_seen <= 1'b1;
      end

      // The SCL fall that closes a START carries no bit, so only count falls after a sampled bit
      if (w_start) begin
        o_bit_idx  <= 4'd0;
        r_bit_seen <= 1'b0;
      end else if (w_busy && w_fall && r_bit_seen) begin
        o_bit_idx  <= (o_bit_idx == 4'd8) ? 4'd0 : o_bit_idx + 4'd1;
        r_bit_seen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb/tb_i2c_bus_monitor.sv - scoreboard bench for i2c_bus_monitor
module tb_i2c_bus_monitor;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_scl = 1'b1;
  logic       i_sda = 1'b1;
  logic       o_scl_rise, o_scl_fall, o_start, o_rstart, o_stop;
  logic       o_bit_valid, o_bit, o_busy, o_bus_free, o_tbuf_viol, o_scl_timeout;
  logic [3:0] o_bit_idx;

  i2c_bus_monitor #(.BUS_FREE_CYCLES(64), .SCL_LOW_TIMEOUT(200)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_scl(i_scl), .i_sda(i_sda),
    .o_scl_rise(o_scl_rise), .o_scl_fall(o_scl_fall), .o_start(o_start),
    .o_rstart(o_rstart), .o_stop(o_stop), .o_bit_valid(o_bit_valid), .o_bit(o_bit),
    .o_bit_idx(o_bit_idx), .o_busy(o_busy), .o_bus_free(o_bus_free),
    .o_tbuf_viol(o_tbuf_viol), .o_scl_timeout(o_scl_timeout)
  );

  always #5 i_clk = ~i_clk;

  // event = {start, rstart, stop, tbuf, bit_valid, bit, idx[3:0], busy}
  typedef logic [10:0] ev_t;
  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  n_rise = 0;
  int  n_fall = 0;

  localparam logic [8:0] BYTE_A5 = 9'b101001010;
  localparam logic [8:0] BYTE_5A = 9'b010110100;

  function automatic ev_t ev(input logic st, rs, sp, tb, bv, b, input logic [3:0] idx, input logic busy);
    return {st, rs, sp, tb, bv, b, idx, busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_scl_rise) n_rise++;
      if (o_scl_fall) n_fall++;
      if (o_start | o_rstart | o_stop | o_bit_valid | o_tbuf_viol) begin
        ev_t act;
        act = {o_start, o_rstart, o_stop, o_tbuf_viol, o_bit_valid, o_bit & o_bit_valid, o_bit_idx, o_busy};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got %b expected none", act);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL event: got %b expected %b", act, e);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drive(input logic scl, input logic sda, input int n);
    i_scl = scl;
    i_sda = sda;
    step(n);
  endtask

  task automatic do_start(input logic tbuf, input logic from_busy);
    exp_q.push_back(ev(~from_busy, from_busy, 1'b0, tbuf, 1'b0, 1'b0, 4'd0, 1'b1));
    drive(1'b1, 1'b0, 4);
  endtask

  task automatic do_bit(input logic b, input logic [3:0] idx);
    drive(1'b0, i_sda, 2);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, b, idx, 1'b1));
    drive(1'b0, b, 2);
    drive(1'b1, b, 4);
  endtask

  task automatic do_stop(input logic [3:0] idx);
    do_bit(1'b0, idx);
    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, idx, 1'b0));
    drive(1'b1, 1'b1, 4);
  endtask

  initial begin
    int first_to;

    // reset and bus-free qualification
    step(2);
    check("reset_busy", o_busy, 0);
    check("reset_bus_free", o_bus_free, 0);
    check("reset_bit_idx", o_bit_idx, 0);
    check("reset_bit", o_bit, 0);
    i_rst_n = 1'b1;
    step(63);
    check("bus_free_before_64", o_bus_free, 0);
    step(1);
    check("bus_free_at_64", o_bus_free, 1);
    check("no_edges_idle", n_rise + n_fall, 0);

    // START, 0xA5 + ACK, STOP
    do_start(1'b0, 1'b0);
    check("busy_after_start", o_busy, 1);
    for (int i = 0; i < 9; i++) do_bit(BYTE_A5[8-i], i[3:0]);
    do_stop(4'd0);
    check("busy_after_stop", o_busy, 0);
    check("free_after_stop", o_bus_free, 0);

    // repeated START after ACK
    drive(1'b1, 1'b1, 70);
    check("free_again", o_bus_free, 1);
    do_start(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) do_bit(BYTE_5A[8-i], i[3:0]);
    do_bit(1'b1, 4'd0);
    do_start(1'b0, 1'b1);
    check("busy_after_rstart", o_busy, 1);
    check("idx_after_rstart", o_bit_idx, 0);
    do_bit(1'b1, 4'd0);
    do_bit(1'b1, 4'd1);
    do_stop(4'd2);

    // START 10 clk after STOP -> tBUF violation
    drive(1'b1, 1'b1, 6);
    check("free_wait_tbuf", o_bus_free, 0);
    do_start(1'b1, 1'b0);
    check("busy_after_tbuf_start", o_busy, 1);

    // SCL stuck low with SDA toggling
    first_to = 0;
    i_scl = 1'b0;
    for (int k = 1; k <= 250; k++) begin
      i_sda = ((k / 3) % 2) != 0;
      step(1);
      if (o_scl_timeout && first_to == 0) first_to = k;
    end
    check("timeout_cycle", first_to, 200);
    check("timeout_level", o_scl_timeout, 1);
    check("timeout_busy", o_busy, 0);
    check("timeout_free", o_bus_free, 0);
    drive(1'b1, 1'b1, 1);
    check("timeout_clear", o_scl_timeout, 0);

    // simultaneous SCL/SDA fall in IDLE
    drive(1'b1, 1'b1, 70);
    check("free_before_simul", o_bus_free, 1);
    begin
      int f0;
      f0 = n_fall;
      drive(1'b0, 1'b0, 4);
      check("simul_fall_count", n_fall - f0, 1);
    end
    check("simul_idle", o_bus_free, 1);
    check("simul_not_busy", o_busy, 0);
    drive(1'b1, 1'b1, 4);
    check("simul_idle_after", o_bus_free, 1);

    step(5);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
